gen_if_skid_stage: RTL and testbench
====================================

Name: gen_if_skid_stage

Overview:
Parameterised valid/ready pipeline stage that carries a data word from an upstream producer to a downstream consumer. A generate-if on MODE selects the implementation: combinational pass-through, single register slice, or full-throughput skid buffer. An optional INC parameter applies the "+1" data transform at the output.

Parameters:
WIDTH, 8, data width in bits (>= 1)
MODE, 2, implementation: 0 = pass-through, 1 = register slice, 2 = skid buffer; any other value is an elaboration error
INC, 0, 0 = data unchanged; 1 = out_data = in_data + 1'b1, modulo 2^WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  stage accepts a word this cycle
in_data  input  WIDTH  upstream word
out_valid  output  1  downstream word valid
out_ready  input  1  downstream accepts a word this cycle
out_data  output  WIDTH  downstream word (transformed if INC=1)

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). All state clears immediately on rst assertion, regardless of clk.
- Transfer occurs on a rising edge where valid && ready are both high, on either side.
- INC transform is applied at capture (MODE 1/2) or combinationally (MODE 0). Wrap: all-ones -> 0, carry is discarded.
- MODE 0: no state. out_valid = in_valid, out_data = f(in_data), in_ready = out_ready. rst has no effect. Latency 0.
- MODE 1: one data register plus a full flag.
  - in_ready = !full || out_ready (combinational from out_ready).
  - Reset: full=0, out_valid=0, out_data=0.
  - Latency 1 cycle. Throughput 1 word/cycle when out_ready is held high.
  - Simultaneous pop and push while full: new word replaces old; full stays 1.
- MODE 2: main register plus skid register. in_ready is registered, so there is no combinational in->out path on ready or valid.
  - States:
    - EMPTY: out_valid=0, in_ready=1
    - BUSY: main valid, in_ready=1
    - FULL: main and skid valid, in_ready=0
  - Transitions:
    - EMPTY -push-> BUSY
    - BUSY -push&&!pop-> FULL (word goes to skid)
    - BUSY -pop&&!push-> EMPTY
    - BUSY -push&&pop-> BUSY (main reloads)
    - FULL -pop-> BUSY (skid moves to main)
  - A push in FULL cannot occur because in_ready=0.
  - Reset: state=EMPTY, out_valid=0, out_data=0, in_ready=0 while rst is high, then in_ready=1 from the first clk edge after deassertion.
  - Latency 1 cycle. Sustained 1 word/cycle. Order is preserved.
- Reset mid-operation: held words are dropped with no output pulse. out_valid falls asynchronously.
- out_data is stable while out_valid && !out_ready (all modes with state).
- in_data is ignored when in_valid=0. No X must propagate into out_data while out_valid=0.

Decomposition:
- Package gen_if_pkg:
  - MODE_PASS=0, MODE_REG=1, MODE_SKID=2 constants
  - skid_state_e enum {EMPTY, BUSY, FULL}
  - function inc_word(width-generic via parameterised class or WIDTH-sized logic)
- One sub-module: gen_if_skid_core (MODE 2 datapath and FSM), instantiated from the MODE==2 generate branch.
- MODE 0/1 are inline generate branches. The else-branch raises $error for an illegal MODE.

Test Plan:
- MODE=2, INC=0, WIDTH=8: reset, then stream 0x00..0x0F with out_ready=1 -> out_data 0x00..0x0F on consecutive cycles, first word 1 cycle after push, no bubbles.
- MODE=2: push 0xA1,0xA2 with out_ready=0 -> in_ready drops after 2nd accept, out_data holds 0xA1; raise out_ready -> 0xA1 then 0xA2; in_ready returns 1 a cycle after first pop.
- MODE=1, INC=1: push 0xFF then 0x7F -> out_data 0x00 then 0x80; with out_ready=0 and full, in_ready=0; simultaneous push/pop keeps out_valid=1.
- MODE=0, INC=1, WIDTH=4: in_data=4'hF, in_valid=1, out_ready=0 -> out_valid=1, out_data=4'h0, in_ready=0 in the same cycle.
- MODE=2 in FULL: assert rst between clock edges -> out_valid=0, out_data=0 immediately; after release, the next push 0x55 emerges alone (no stale 0xA2).
- Elaborate MODE=3 -> elaboration fails with $error.

Source files
------------

// File: rtl/gen_if_pkg.sv
// Shared constants, skid FSM state type and the optional "+1" data transform
// used by every gen_if_skid_stage implementation.
package gen_if_pkg;

  localparam int MODE_PASS = 0;
  localparam int MODE_REG  = 1;
  localparam int MODE_SKID = 2;

  // Widest word inc_word can carry; callers zero-extend in and truncate out.
  localparam int INC_MAXW  = 256;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Truncating the result back to the caller's width discards the carry,
  // so all-ones wraps to zero.
  function automatic logic [INC_MAXW-1:0] inc_word(input logic [INC_MAXW-1:0] w,
                                                    input logic              en);
    return en ? w + INC_MAXW'(1) : w;
  endfunction

endpackage

// File: rtl/gen_if_skid_core.sv
// Full-throughput skid buffer: main + skid register, registered in_ready,
// no combinational path from the downstream side back to the upstream side.
module gen_if_skid_core
  import gen_if_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             rdy_q, vld_q;
  logic             push, pop;

  assign push = in_valid && rdy_q;
  assign pop  = vld_q && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (push) state_d = BUSY;
      BUSY: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = BUSY;
      default: state_d = EMPTY;
    endcase
  end

  // rdy_q stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= (state_d != EMPTY);
      rdy_q   <= (state_d != FULL);
      case (state_q)
        EMPTY: if (push) main_q <= in_data;
        BUSY: begin
          if (push && pop) main_q <= in_data;
          else if (push)   skid_q <= in_data;
        end
        FULL:  if (pop) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_data  = main_q;

endmodule

// File: rtl/gen_if_skid_stage.sv
// Valid/ready pipeline stage; MODE picks pass-through, register slice or
// skid buffer, INC optionally adds one to every word passing through.
module gen_if_skid_stage
  import gen_if_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = 2,
  parameter int INC   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] xf_data;

  assign xf_data = WIDTH'(inc_word(INC_MAXW'(in_data), INC != 0));

  if (WIDTH < 1 || WIDTH > INC_MAXW) begin : g_bad_width
    $error("gen_if_skid_stage: WIDTH %0d out of range", WIDTH);
  end

  if (MODE == MODE_PASS) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_valid      = in_valid;
    assign out_data       = xf_data;
    assign in_ready       = out_ready;

  end else if (MODE == MODE_REG) begin : g_reg
    logic             full_q;
    logic [WIDTH-1:0] data_q;
    logic             push, pop;

    assign in_ready = !full_q || out_ready;
    assign push     = in_valid && in_ready;
    assign pop      = full_q && out_ready;

    // A push during a pop overwrites the departing word and keeps full set.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        full_q <= 1'b0;
        data_q <= '0;
      end else if (push) begin
        full_q <= 1'b1;
        data_q <= xf_data;
      end else if (pop) begin
        full_q <= 1'b0;
      end
    end

    assign out_valid = full_q;
    assign out_data  = data_q;

  end else if (MODE == MODE_SKID) begin : g_skid
    gen_if_skid_core #(.WIDTH(WIDTH)) u_core (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (xf_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
    );

  end else begin : g_bad_mode
    $error("gen_if_skid_stage: illegal MODE %0d", MODE);
  end

endmodule

// File: tb/tb_gen_if_skid_stage.sv
// Directed bench for gen_if_skid_stage: skid (MODE 2), register slice
// (MODE 1, INC) and pass-through (MODE 0, INC, WIDTH 4) instances.
module tb_gen_if_skid_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s, rst_r;
  logic       s_iv, s_ir, s_ov, s_or;
  logic [7:0] s_d, s_od;
  logic       r_iv, r_ir, r_ov, r_or;
  logic [7:0] r_d, r_od;
  logic       p_iv, p_ir, p_ov, p_or;
  logic [3:0] p_d, p_od;

  gen_if_skid_stage #(.WIDTH(8), .MODE(2), .INC(0)) u_skid (
    .clk(clk), .rst(rst_s), .in_valid(s_iv), .in_ready(s_ir), .in_data(s_d),
    .out_valid(s_ov), .out_ready(s_or), .out_data(s_od));

  gen_if_skid_stage #(.WIDTH(8), .MODE(1), .INC(1)) u_reg (
    .clk(clk), .rst(rst_r), .in_valid(r_iv), .in_ready(r_ir), .in_data(r_d),
    .out_valid(r_ov), .out_ready(r_or), .out_data(r_od));

  gen_if_skid_stage #(.WIDTH(4), .MODE(0), .INC(1)) u_pass (
    .clk(clk), .rst(rst_r), .in_valid(p_iv), .in_ready(p_ir), .in_data(p_d),
    .out_valid(p_ov), .out_ready(p_or), .out_data(p_od));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       ov;
    logic [7:0] od;
    logic       ir;
  } vec_t;

  vec_t m1[10];
  vec_t m0[4];

  // Drive right after a rising edge, sample at the following falling edge.
  task automatic s_cycle(input logic iv, input logic [7:0] d, input logic ordy);
    @(posedge clk); #1;
    s_iv = iv; s_d = d; s_or = ordy;
    @(negedge clk);
  endtask

  initial begin
    // register slice, INC=1: columns iv, d, out_ready -> out_valid, out_data, in_ready
    m1[0] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1};
    m1[1] = '{1'b1, 8'h7F, 1'b0, 1'b1, 8'h00, 1'b0};
    m1[2] = '{1'b1, 8'h7F, 1'b1, 1'b1, 8'h00, 1'b1};
    m1[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0};
    m1[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h80, 1'b1};
    m1[5] = '{1'b0, 8'h33, 1'b1, 1'b0, 8'h00, 1'b1};
    m1[6] = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 1'b1};
    m1[7] = '{1'b1, 8'h20, 1'b1, 1'b1, 8'h11, 1'b1};
    m1[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h21, 1'b1};
    m1[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1};
    // pass-through, WIDTH 4, INC=1 (only low nibble of d/od used)
    m0[0] = '{1'b1, 8'h0F, 1'b0, 1'b1, 8'h00, 1'b0};
    m0[1] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h04, 1'b1};
    m0[2] = '{1'b0, 8'h07, 1'b1, 1'b0, 8'h08, 1'b1};
    m0[3] = '{1'b0, 8'h0E, 1'b0, 1'b0, 8'h0F, 1'b0};

    rst_s = 1'b1; rst_r = 1'b1;
    s_iv = 0; s_d = 0; s_or = 0;
    r_iv = 0; r_d = 0; r_or = 0;
    p_iv = 0; p_d = 0; p_or = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("skid_rst_ov", s_ov, 1'b0);
    chk("skid_rst_od", s_od, 8'h00);
    chk("skid_rst_ir", s_ir, 1'b0);
    chk("reg_rst_ov",  r_ov, 1'b0);
    chk("reg_rst_od",  r_od, 8'h00);
    rst_s = 1'b0; rst_r = 1'b0;
    @(posedge clk); #1;
    chk("skid_ir_after_rst", s_ir, 1'b1);

    // pass-through table, purely combinational
    for (int i = 0; i < 4; i++) begin
      p_iv = m0[i].iv; p_d = m0[i].d[3:0]; p_or = m0[i].ordy;
      #1;
      chk($sformatf("pass[%0d]_ov", i), p_ov, m0[i].ov);
      chk($sformatf("pass[%0d]_od", i), p_od, m0[i].od[3:0]);
      chk($sformatf("pass[%0d]_ir", i), p_ir, m0[i].ir);
    end

    // register slice table
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      r_iv = m1[i].iv; r_d = m1[i].d; r_or = m1[i].ordy;
      @(negedge clk);
      chk($sformatf("reg[%0d]_ov", i), r_ov, m1[i].ov);
      if (m1[i].ov) chk($sformatf("reg[%0d]_od", i), r_od, m1[i].od);
      chk($sformatf("reg[%0d]_ir", i), r_ir, m1[i].ir);
    end

    // skid: 16-word stream, one-cycle latency, no bubbles
    for (int k = 0; k <= 16; k++) begin
      s_cycle(k < 16, 8'(k), 1'b1);
      chk($sformatf("stream[%0d]_ir", k), s_ir, 1'b1);
      chk($sformatf("stream[%0d]_ov", k), s_ov, k != 0);
      if (k != 0) chk($sformatf("stream[%0d]_od", k), s_od, 8'(k - 1));
    end
    s_cycle(1'b0, 8'h00, 1'b1);
    chk("stream_drained_ov", s_ov, 1'b0);

    // skid: backpressure fills main then skid; third word must be refused
    s_cycle(1'b1, 8'hA1, 1'b0);
    chk("bp0_ir", s_ir, 1'b1); chk("bp0_ov", s_ov, 1'b0);
    s_cycle(1'b1, 8'hA2, 1'b0);
    chk("bp1_ir", s_ir, 1'b1); chk("bp1_ov", s_ov, 1'b1); chk("bp1_od", s_od, 8'hA1);
    s_cycle(1'b1, 8'hA3, 1'b0);
    chk("bp2_ir", s_ir, 1'b0); chk("bp2_ov", s_ov, 1'b1); chk("bp2_od", s_od, 8'hA1);
    s_cycle(1'b0, 8'h00, 1'b1);
    chk("bp3_ir", s_ir, 1'b0); chk("bp3_od", s_od, 8'hA1);
    s_cycle(1'b0, 8'h00, 1'b1);
    chk("bp4_ir", s_ir, 1'b1); chk("bp4_ov", s_ov, 1'b1); chk("bp4_od", s_od, 8'hA2);
    s_cycle(1'b0, 8'h00, 1'b1);
    chk("bp5_ov", s_ov, 1'b0);

    // skid: async reset while FULL drops both words
    s_cycle(1'b1, 8'hA1, 1'b0);
    s_cycle(1'b1, 8'hA2, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b0);
    chk("full_ir", s_ir, 1'b0); chk("full_ov", s_ov, 1'b1);
    #1 rst_s = 1'b1;
    #1;
    chk("async_rst_ov", s_ov, 1'b0);
    chk("async_rst_od", s_od, 8'h00);
    chk("async_rst_ir", s_ir, 1'b0);
    @(negedge clk);
    rst_s = 1'b0;
    s_cycle(1'b0, 8'h00, 1'b1);
    chk("post_rst_ov", s_ov, 1'b0);
    chk("post_rst_ir", s_ir, 1'b1);
    s_cycle(1'b1, 8'h55, 1'b1);
    chk("p55_ov0", s_ov, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b1);
    chk("p55_ov1", s_ov, 1'b1); chk("p55_od", s_od, 8'h55);
    s_cycle(1'b0, 8'h00, 1'b1);
    chk("p55_no_stale_ov", s_ov, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b1);
    chk("p55_no_stale_ov2", s_ov, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
